// File: rtl/keccak_chi_dom_pipe_if.sv
// Handshake and data bundle for the masked chi stage: producer side (master) and stage side (slave).
interface keccak_chi_dom_pipe_if #(
  parameter int unsigned SHARES    = 2,
  parameter int unsigned ROWS      = 5,
  parameter int unsigned LESS_RAND = 1,
  parameter int unsigned CNT_W     = 8
);
  localparam int unsigned DataW    = SHARES * ROWS * 5;
  localparam int unsigned RandRawW = (SHARES * (SHARES - 1) / 2 - LESS_RAND) * ROWS * 5;
  localparam int unsigned RandW    = (RandRawW > 0) ? RandRawW : 1;

  logic             InValidxSI;
  logic             InReadyxSO;
  logic             RandValidxSI;
  logic [DataW-1:0] InputxDI;
  logic [RandW-1:0] ZxDI;
  logic             IotaRCxDI;
  logic             OutValidxSO;
  logic             OutReadyxSI;
  logic [DataW-1:0] OutputxDO;
  logic [CNT_W-1:0] BeatCntxDO;

  modport slave (
    input  InValidxSI, RandValidxSI, InputxDI, ZxDI, IotaRCxDI, OutReadyxSI,
    output InReadyxSO, OutValidxSO, OutputxDO, BeatCntxDO
  );

  modport master (
    output InValidxSI, RandValidxSI, InputxDI, ZxDI, IotaRCxDI, OutReadyxSI,
    input  InReadyxSO, OutValidxSO, OutputxDO, BeatCntxDO
  );
endinterface

// File: rtl/keccak_chi_dom_pipe.sv
// DOM-masked Keccak chi (+ optional iota) over ROWS 5-bit rows with a one-deep valid/ready stage.
// Share products are registered uncompressed; share recombination happens after the flops.
module keccak_chi_dom_pipe #(
  parameter int unsigned SHARES    = 2,
  parameter int unsigned ROWS      = 5,
  parameter int unsigned LESS_RAND = 1,
  parameter int unsigned IOTA_EN   = 1,
  parameter int unsigned CNT_W     = 8
) (
  input logic                    ClkxCI,
  input logic                    RstxRI,
  keccak_chi_dom_pipe_if.slave   bus
);

  localparam int          Sh    = SHARES;
  localparam int          Rw    = ROWS;
  localparam int          Pairs = SHARES * (SHARES - 1) / 2;
  localparam int          ZUsed = Pairs - int'(LESS_RAND);
  localparam int unsigned RowW  = ROWS * 5;
  localparam int unsigned DataW = SHARES * RowW;
  localparam int unsigned FfW   = SHARES * SHARES * RowW;

  logic [FfW-1:0]   ff_q, ff_d;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DataW-1:0] out_d;
  logic             in_ready, accept;
  logic             sx0, sx1, sx2, tx2, term;
  int               lo, hi, p;
  logic             unused_in;

  assign in_ready = ~out_valid_q | bus.OutReadyxSI;
  assign accept   = bus.InValidxSI & bus.RandValidxSI & in_ready;

  // FF(i,j) holds the (i,j) domain term; randomness is consumed only on accept.
  always_comb begin : chi_terms
    ff_d = ff_q;
    sx0  = 1'b0;
    sx1  = 1'b0;
    sx2  = 1'b0;
    tx2  = 1'b0;
    term = 1'b0;
    lo   = 0;
    hi   = 0;
    p    = 0;
    if (accept) begin
      for (int i = 0; i < Sh; i++) begin
        for (int j = 0; j < Sh; j++) begin
          for (int r = 0; r < Rw; r++) begin
            for (int x = 0; x < 5; x++) begin
              sx0 = bus.InputxDI[(i*Rw+r)*5 + x];
              sx1 = bus.InputxDI[(i*Rw+r)*5 + (x+1)%5];
              sx2 = bus.InputxDI[(i*Rw+r)*5 + (x+2)%5];
              tx2 = bus.InputxDI[(j*Rw+r)*5 + (x+2)%5];
              if (i == j) begin
                // The last pair's cross terms carry S[x0] for these two shares instead.
                if (LESS_RAND != 0 && i >= Sh - 2) term = ~sx1 & sx2;
                else                               term = sx0 ^ (~sx1 & sx2);
              end else begin
                lo = (i < j) ? i : j;
                hi = (i < j) ? j : i;
                p  = lo + hi * (hi - 1) / 2;
                if (p < ZUsed) term = (sx1 & tx2) ^ bus.ZxDI[(p*Rw+r)*5 + x];
                else           term = (sx1 & tx2) ^ sx0;
              end
              ff_d[((i*Sh+j)*Rw+r)*5 + x] = term;
            end
          end
        end
      end
      if (IOTA_EN != 0) ff_d[RowW] = ff_d[RowW] ^ bus.IotaRCxDI;
    end
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      ff_q        <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ff_q <= ff_d;
      if (accept)                out_valid_q <= 1'b1;
      else if (bus.OutReadyxSI)  out_valid_q <= 1'b0;
      if (accept) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin : compress
    out_d = '0;
    for (int i = 0; i < Sh; i++) begin
      for (int j = 0; j < Sh; j++) begin
        out_d[i*RowW +: RowW] = out_d[i*RowW +: RowW] ^ ff_q[(i*Sh+j)*RowW +: RowW];
      end
    end
  end

  assign bus.InReadyxSO  = in_ready;
  assign bus.OutValidxSO = out_valid_q;
  assign bus.OutputxDO   = out_d;
  assign bus.BeatCntxDO  = cnt_q;

  // Some configurations never read Z or the round constant.
  assign unused_in = ^{bus.ZxDI, bus.IotaRCxDI};

endmodule

// File: tb/tb_keccak_chi_dom_pipe.sv
// Bench for keccak_chi_dom_pipe: directed vectors/sequences on a 2-share instance plus
// randomized handshake traffic on several share/LESS_RAND configurations.
module tb_keccak_chi_dom_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rnd_done_n = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference chi on the unmasked 5-row state, iota on row 0 bit 0.
  function automatic logic [24:0] chi_ref(input logic [24:0] a, input logic rc);
    logic [24:0] y;
    for (int r = 0; r < 5; r++)
      for (int x = 0; x < 5; x++)
        y[r*5+x] = a[r*5+x] ^ (~a[r*5+(x+1)%5] & a[r*5+(x+2)%5]);
    y[0] = y[0] ^ rc;
    return y;
  endfunction

  function automatic logic [24:0] unmask(input logic [99:0] v, input int s);
    logic [24:0] u = '0;
    for (int k = 0; k < s; k++) u = u ^ v[k*25 +: 25];
    return u;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed instance: 2 shares, LESS_RAND, 4-bit counter ----------------
  logic rst_a;
  keccak_chi_dom_pipe_if #(.SHARES(2), .ROWS(5), .LESS_RAND(1), .CNT_W(4)) bus_a ();
  keccak_chi_dom_pipe #(.SHARES(2), .ROWS(5), .LESS_RAND(1), .IOTA_EN(1), .CNT_W(4)) dut_a (
    .ClkxCI (clk),
    .RstxRI (rst_a),
    .bus    (bus_a)
  );

  task automatic drive_a(input logic [24:0] u, input logic [24:0] m, input logic rc,
                         input logic v, input logic rv, input logic ordy);
    bus_a.InputxDI     = {m ^ u, m};
    bus_a.ZxDI         = 1'b0;
    bus_a.IotaRCxDI    = rc;
    bus_a.InValidxSI   = v;
    bus_a.RandValidxSI = rv;
    bus_a.OutReadyxSI  = ordy;
  endtask

  function automatic logic [24:0] out_a();
    return unmask(100'(bus_a.OutputxDO), 2);
  endfunction

  typedef struct {
    logic [24:0] u;
    logic [24:0] m;
    logic        rc;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int cnt_e;
    logic [24:0] ux, uw, ur;
    logic [24:0] bp_u [3];
    logic        rc;

    vecs[0] = '{25'h0000001, 25'h0A5F3C1, 1'b0, 25'h0000009};
    vecs[1] = '{25'h0000001, 25'h13C96E4, 1'b1, 25'h0000008};
    vecs[2] = '{25'h1FFFFFF, 25'h05A5A5A, 1'b0, 25'h1FFFFFF};
    vecs[3] = '{25'h1FFFFFF, 25'h1234567, 1'b1, 25'h1FFFFFE};
    vecs[4] = '{25'h0000000, 25'h0F0F0F0, 1'b1, 25'h0000001};
    vecs[5] = '{25'h0000020, 25'h1E1E1E1, 1'b0, 25'h0000120};
    vecs[6] = '{25'h0000003, 25'h0C3C3C3, 1'b0, 25'h000000B};
    vecs[7] = '{25'h0000005, 25'h1999999, 1'b0, 25'h000000C};

    // Reset with a live beat on the inputs: it must be discarded.
    rst_a = 1'b1;
    drive_a(25'h1ABCDEF, 25'h0123456, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    step();
    chk("rst_valid", 160'(bus_a.OutValidxSO), 160'(0));
    chk("rst_out",   160'(bus_a.OutputxDO),   160'(0));
    chk("rst_cnt",   160'(bus_a.BeatCntxDO),  160'(0));
    chk("rst_ready", 160'(bus_a.InReadyxSO),  160'(1));
    rst_a = 1'b0;
    drive_a('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("idle_valid", 160'(bus_a.OutValidxSO), 160'(0));
    cnt_e = 0;

    // Vector table, back-to-back beats with the consumer always ready.
    for (int k = 0; k < 8; k++) begin
      drive_a(vecs[k].u, vecs[k].m, vecs[k].rc, 1'b1, 1'b1, 1'b1);
      step();
      cnt_e++;
      chk($sformatf("vec%0d_valid", k), 160'(bus_a.OutValidxSO), 160'(1));
      chk($sformatf("vec%0d_out", k),   160'(out_a()),           160'(vecs[k].exp));
      chk($sformatf("vec%0d_cnt", k),   160'(bus_a.BeatCntxDO),  160'(cnt_e % 16));
    end
    drive_a('0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("drain_valid", 160'(bus_a.OutValidxSO), 160'(0));

    // Backpressure: one beat held while the next waits for five cycles.
    ux = 25'h0D15EA5;
    drive_a(ux, 25'h1357913, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    cnt_e++;
    chk("bp_load_valid", 160'(bus_a.OutValidxSO), 160'(1));
    bp_u[0] = 25'h0BADF00;
    bp_u[1] = 25'h1C0FFEE;
    bp_u[2] = 25'h0FACADE;
    drive_a(bp_u[0], 25'h0777777, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("bp%0d_ready", k), 160'(bus_a.InReadyxSO),  160'(0));
      chk($sformatf("bp%0d_valid", k), 160'(bus_a.OutValidxSO), 160'(1));
      chk($sformatf("bp%0d_out", k),   160'(out_a()),           160'(chi_ref(ux, 1'b0)));
      chk($sformatf("bp%0d_cnt", k),   160'(bus_a.BeatCntxDO),  160'(cnt_e % 16));
    end
    for (int k = 0; k < 3; k++) begin
      drive_a(bp_u[k], 25'h0777777 ^ 25'(k), 1'b0, 1'b1, 1'b1, 1'b1);
      step();
      cnt_e++;
      chk($sformatf("flow%0d_out", k), 160'(out_a()),          160'(chi_ref(bp_u[k], 1'b0)));
      chk($sformatf("flow%0d_cnt", k), 160'(bus_a.BeatCntxDO), 160'(cnt_e % 16));
    end

    // Randomness not valid: the held beat is taken, nothing new enters, flops keep their value.
    uw = bp_u[2];
    drive_a(25'h1111111, 25'h0222222, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rv%0d_valid", k), 160'(bus_a.OutValidxSO), 160'(0));
      chk($sformatf("rv%0d_out", k),   160'(out_a()),           160'(chi_ref(uw, 1'b0)));
      chk($sformatf("rv%0d_cnt", k),   160'(bus_a.BeatCntxDO),  160'(cnt_e % 16));
    end
    bus_a.RandValidxSI = 1'b1;
    step();
    cnt_e++;
    chk("rv_go_valid", 160'(bus_a.OutValidxSO), 160'(1));
    chk("rv_go_out",   160'(out_a()),           160'(chi_ref(25'h1111111, 1'b1)));

    // Counter wrap: 17 beats from reset on a 4-bit counter.
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    cnt_e = 0;
    for (int k = 0; k < 17; k++) begin
      ur = 25'($urandom);
      rc = 1'($urandom_range(0, 1));
      drive_a(ur, 25'($urandom), rc, 1'b1, 1'b1, 1'b1);
      step();
      cnt_e++;
      chk($sformatf("wrap%0d_out", k), 160'(out_a()), 160'(chi_ref(ur, rc)));
    end
    chk("wrap_cnt", 160'(bus_a.BeatCntxDO), 160'(1));

    // Reset while a beat is held.
    drive_a(25'h0F0F0F0, 25'h1010101, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk("rstv_pre_valid", 160'(bus_a.OutValidxSO), 160'(1));
    rst_a = 1'b1;
    step();
    chk("rstv_valid", 160'(bus_a.OutValidxSO), 160'(0));
    chk("rstv_out",   160'(bus_a.OutputxDO),   160'(0));
    chk("rstv_cnt",   160'(bus_a.BeatCntxDO),  160'(0));
    rst_a = 1'b0;
    drive_a('0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("rstv_after_valid", 160'(bus_a.OutValidxSO), 160'(0));

    for (int c = 0; c < 40000 && rnd_done_n < 5; c++) @(posedge clk);
    if (rnd_done_n < 5) begin
      total++;
      bad++;
      $display("FAIL rnd_timeout: got %0d done want 5", rnd_done_n);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- randomized instances ----------------
  localparam int unsigned CFG_S [5] = '{2, 3, 4, 3, 4};
  localparam int unsigned CFG_L [5] = '{0, 0, 1, 1, 0};

  for (genvar g = 0; g < 5; g++) begin : g_rnd
    localparam int unsigned S    = CFG_S[g];
    localparam int unsigned L    = CFG_L[g];
    localparam int unsigned DW   = S * 25;
    localparam int unsigned ZRaw = (S * (S - 1) / 2 - L) * 25;
    localparam int unsigned ZW   = (ZRaw > 0) ? ZRaw : 1;

    logic rst;
    keccak_chi_dom_pipe_if #(.SHARES(S), .ROWS(5), .LESS_RAND(L), .CNT_W(8)) bus ();
    keccak_chi_dom_pipe #(.SHARES(S), .ROWS(5), .LESS_RAND(L), .IOTA_EN(1), .CNT_W(8)) dut (
      .ClkxCI (clk),
      .RstxRI (rst),
      .bus    (bus)
    );

    initial begin
      logic [24:0]  q [$];
      logic [159:0] rd;
      logic         exp_ready, acc, take;
      logic [7:0]   cnt_m;
      int           beats, cyc;

      beats = 0;
      cyc   = 0;
      cnt_m = '0;
      rst   = 1'b1;
      bus.InValidxSI   = 1'b0;
      bus.RandValidxSI = 1'b0;
      bus.OutReadyxSI  = 1'b0;
      bus.IotaRCxDI    = 1'b0;
      bus.InputxDI     = '0;
      bus.ZxDI         = '0;
      step();
      step();
      rst = 1'b0;
      while (beats < 10000 && cyc < 30000) begin
        rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
        bus.InputxDI = rd[DW-1:0];
        rd = {$urandom, $urandom, $urandom, $urandom, $urandom};
        bus.ZxDI = rd[ZW-1:0];
        bus.IotaRCxDI    = 1'($urandom_range(0, 1));
        bus.InValidxSI   = ($urandom_range(0, 7) != 0);
        bus.RandValidxSI = ($urandom_range(0, 7) != 0);
        bus.OutReadyxSI  = ($urandom_range(0, 7) != 0);
        #1;
        exp_ready = (q.size() == 0) || bus.OutReadyxSI;
        chk($sformatf("rnd%0d_ready", g), 160'(bus.InReadyxSO),  160'(exp_ready));
        chk($sformatf("rnd%0d_valid", g), 160'(bus.OutValidxSO), 160'(q.size() != 0));
        if (q.size() != 0)
          chk($sformatf("rnd%0d_out", g), 160'(unmask(100'(bus.OutputxDO), S)), 160'(q[0]));
        take = (q.size() != 0) && bus.OutReadyxSI;
        acc  = bus.InValidxSI && bus.RandValidxSI && exp_ready;
        if (take) void'(q.pop_front());
        if (acc) begin
          q.push_back(chi_ref(unmask(100'(bus.InputxDI), S), bus.IotaRCxDI));
          beats++;
          cnt_m = cnt_m + 8'd1;
        end
        step();
        cyc++;
      end
      chk($sformatf("rnd%0d_beats", g), 160'(beats), 160'(10000));
      chk($sformatf("rnd%0d_cnt", g), 160'(bus.BeatCntxDO), 160'(cnt_m));
      rnd_done_n++;
    end
  end

endmodule
